cache_mem_ctrl: RTL

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

---
 rtl/cache_mem_if.sv | 37 +++
 rtl/cache_mem_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cache_mem_if.sv
// Miss-handling bus between cache FSM / memory and cache_mem_ctrl.
// The slave modport is the controller view; master is the surrounding cache and memory.
interface cache_mem_if #(
    parameter int unsigned PA_WIDTH  = 32,
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned BLK_BEATS = 4
);
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_dirty;
    logic [PA_WIDTH-1:0]            req_wb_addr;
    logic [PA_WIDTH-1:0]            req_fill_addr;
    logic [BLK_BEATS*MEM_WIDTH-1:0] req_wb_data;
    logic                           fill_valid;
    logic [BLK_BEATS*MEM_WIDTH-1:0] fill_data;
    logic                           fill_err;
    logic [PA_WIDTH-1:0]            mem_addr;
    logic                           mem_rd_en;
    logic                           mem_wr_en;
    logic [MEM_WIDTH-1:0]           mem_wdata;
    logic [MEM_WIDTH-1:0]           mem_rdata;
    logic                           mem_ack;

    modport master (
        output req_valid, req_dirty, req_wb_addr, req_fill_addr, req_wb_data,
        output mem_rdata, mem_ack,
        input  req_ready, fill_valid, fill_data, fill_err,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_dirty, req_wb_addr, req_fill_addr, req_wb_data,
        input  mem_rdata, mem_ack,
        output req_ready, fill_valid, fill_data, fill_err,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata
    );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Cache miss controller: optional dirty-victim writeback burst, then block fill burst.
// Define CACHE_MEM_TIMEOUT_EN to add a per-beat watchdog that aborts with fill_err.
module cache_mem_ctrl #(
    parameter int unsigned PA_WIDTH  = 32,
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned BLK_BEATS = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_mem_if.slave  bus
);
    localparam int unsigned BLK_W   = BLK_BEATS * MEM_WIDTH;
    localparam int unsigned BEAT_W  = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam int unsigned BYTE_SH = $clog2(MEM_WIDTH / 8);
    localparam int unsigned OFF_W   = $clog2(BLK_W / 8);
    localparam logic [PA_WIDTH-1:0] OFF_MASK  = PA_WIDTH'((64'd1 << OFF_W) - 64'd1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BLK_BEATS - 1);

    if (MEM_WIDTH < 8 || (MEM_WIDTH & (MEM_WIDTH - 1)) != 0 ||
        BLK_BEATS == 0 || (BLK_BEATS & (BLK_BEATS - 1)) != 0 || TIMEOUT == 0) begin : g_bad_param
        $error("cache_mem_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [PA_WIDTH-1:0] wb_base_q, wb_base_d;
    logic [PA_WIDTH-1:0] fill_base_q, fill_base_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [BLK_W-1:0]    fill_data_q, fill_data_d;
    logic [PA_WIDTH-1:0] beat_off;

`ifdef CACHE_MEM_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
`endif

    assign beat_off = PA_WIDTH'(beat_q) << BYTE_SH;

    // blk holds the victim during WB; each written-out slice is then reused for the fill beat.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        blk_d       = blk_q;
        fill_data_d = fill_data_q;
`ifdef CACHE_MEM_TIMEOUT_EN
        wdog_d      = wdog_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wb_base_d   = bus.req_wb_addr & ~OFF_MASK;
                    fill_base_d = bus.req_fill_addr & ~OFF_MASK;
                    blk_d       = bus.req_wb_data;
                    beat_d      = '0;
                    state_d     = bus.req_dirty ? WB : FILL;
`ifdef CACHE_MEM_TIMEOUT_EN
                    wdog_d      = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            WB: begin
                if (bus.mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    blk_d[beat_q*MEM_WIDTH +: MEM_WIDTH] = bus.mem_rdata;
                    if (beat_q == LAST_BEAT) begin
                        fill_data_d = blk_d;
                        state_d     = RESP;
                    end else begin
                        beat_d      = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef CACHE_MEM_TIMEOUT_EN
        if (state_q == WB || state_q == FILL) begin
            if (bus.mem_ack) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                wdog_d  = '0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            blk_q       <= '0;
            fill_data_q <= '0;
`ifdef CACHE_MEM_TIMEOUT_EN
            wdog_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            blk_q       <= blk_d;
            fill_data_q <= fill_data_d;
`ifdef CACHE_MEM_TIMEOUT_EN
            wdog_q      <= wdog_d;
            err_q       <= err_d;
`endif
        end
    end

    // State is held at IDLE during reset, so only req_ready needs explicit gating.
    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign bus.mem_wr_en  = (state_q == WB);
    assign bus.mem_rd_en  = (state_q == FILL);
    assign bus.mem_addr   = (state_q == WB)   ? wb_base_q + beat_off :
                            (state_q == FILL) ? fill_base_q + beat_off : '0;
    assign bus.mem_wdata  = (state_q == WB) ? blk_q[beat_q*MEM_WIDTH +: MEM_WIDTH] : '0;
    assign bus.fill_valid = (state_q == RESP);
    assign bus.fill_data  = fill_data_q;
`ifdef CACHE_MEM_TIMEOUT_EN
    assign bus.fill_err   = (state_q == RESP) && err_q;
`else
    assign bus.fill_err   = 1'b0;
`endif
endmodule
